// File: rtl/symbol_sequence_tx.sv
// symbol_sequence_tx
// Transmit side of the 7-bit character sequence link. Accepts 3-bit symbol
// requests over a valid/ready handshake and drives a character plus strobe
// to the sequence recogniser. Keeps a mirror of the recogniser state and
// refuses any symbol the recogniser would reject or ignore. Also sequences
// link restarts through rx_reset.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-high reset
//   sym_valid  symbol request valid
//   sym_id     symbol index 0..7
//   sym_ready  request can be accepted this cycle
//   restart    link restart request (pulse; held pending while busy)
//   tx_char    character to recogniser (held until reset/restart)
//   tx_strobe  character valid strobe, STROBE_LEN cycles per character
//   rx_reset   one-cycle recogniser reset pulse
//   err        one-cycle pulse per refused request
//   state      mirror state: 0..5 active, 8 ACC_A, 9 REJ, 10 ACC_B
//   done       mirror state is terminal
module symbol_sequence_tx #(
    parameter int unsigned STROBE_LEN = 1,
    parameter int unsigned GAP_LEN    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sym_valid,
    input  logic [2:0] sym_id,
    output logic       sym_ready,
    input  logic       restart,
    output logic [6:0] tx_char,
    output logic       tx_strobe,
    output logic       rx_reset,
    output logic       err,
    output logic [3:0] state,
    output logic       done
);

    localparam int unsigned MaxLen = (STROBE_LEN > GAP_LEN) ? STROBE_LEN : GAP_LEN;
    localparam int unsigned CntW   = $clog2(MaxLen + 1);

    // The IDLE cycle in which the next request is sampled counts as the last
    // gap cycle, so the GAP state itself lasts GAP_LEN-1 cycles.
    localparam logic [CntW-1:0] StrobeLast = CntW'(STROBE_LEN - 1);
    localparam logic [CntW-1:0] GapLast    = (GAP_LEN >= 2) ? CntW'(GAP_LEN - 2) : '0;

    typedef enum logic [1:0] {StIdle, StStrobe, StGap, StRestart} fsm_e;

    fsm_e            fsm_q, fsm_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [6:0]      char_q, char_d;
    logic [3:0]      mstate_q, mstate_d;
    logic            pend_q, pend_d;
    logic            err_q, err_d;

    logic       restart_eff;
    logic       legal;
    logic [6:0] sym_char;
    logic [3:0] sym_next;

    // Symbol table: character, legality in the current mirror state, next state.
    always_comb begin
        sym_char = 7'h00;
        sym_next = mstate_q;
        legal    = 1'b0;
        unique case (sym_id)
            3'd0: begin sym_char = 7'h58; sym_next = 4'd1;
                  legal = (mstate_q == 4'd0) || (mstate_q == 4'd2); end
            3'd1: begin sym_char = 7'h6B; sym_next = 4'd2;
                  legal = (mstate_q <= 4'd1) || (mstate_q == 4'd3); end
            3'd2: begin sym_char = 7'h4F; sym_next = 4'd3;
                  legal = (mstate_q == 4'd0) || (mstate_q == 4'd2) || (mstate_q == 4'd4); end
            3'd3: begin sym_char = 7'h28; sym_next = 4'd4;
                  legal = (mstate_q == 4'd0) || (mstate_q == 4'd3) || (mstate_q == 4'd5); end
            3'd4: begin sym_char = 7'h0C; sym_next = 4'd5;
                  legal = (mstate_q == 4'd0) || (mstate_q == 4'd4); end
            3'd5: begin sym_char = 7'h32; sym_next = 4'd8;
                  legal = (mstate_q >= 4'd1) && (mstate_q <= 4'd3); end
            3'd6: begin sym_char = 7'h16; sym_next = 4'd9;
                  legal = (mstate_q <= 4'd5); end
            3'd7: begin sym_char = 7'h23; sym_next = 4'd10;
                  legal = (mstate_q == 4'd4) || (mstate_q == 4'd5); end
            default: ;
        endcase
    end

    assign done        = (mstate_q == 4'd8) || (mstate_q == 4'd9) || (mstate_q == 4'd10);
    assign restart_eff = restart | pend_q;

    always_comb begin
        fsm_d    = fsm_q;
        cnt_d    = cnt_q;
        char_d   = char_q;
        mstate_d = mstate_q;
        pend_d   = pend_q;
        err_d    = 1'b0;
        unique case (fsm_q)
            StIdle: begin
                if (restart_eff) begin
                    // Restart wins over a coincident symbol request.
                    fsm_d    = StRestart;
                    pend_d   = 1'b0;
                    mstate_d = 4'd0;
                    char_d   = 7'h00;
                    cnt_d    = '0;
                end else if (sym_valid) begin
                    if (!done && legal) begin
                        fsm_d    = StStrobe;
                        cnt_d    = '0;
                        char_d   = sym_char;
                        mstate_d = sym_next;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StStrobe: begin
                pend_d = pend_q | restart;
                err_d  = sym_valid & done;
                if (cnt_q == StrobeLast) begin
                    fsm_d = (GAP_LEN > 1) ? StGap : StIdle;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                pend_d = pend_q | restart;
                err_d  = sym_valid & done;
                if (cnt_q == GapLast) begin
                    fsm_d = StIdle;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRestart: begin
                pend_d = pend_q | restart;
                err_d  = sym_valid & done;
                fsm_d  = (GAP_LEN > 1) ? StGap : StIdle;
                cnt_d  = '0;
            end
            default: fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q    <= StIdle;
            cnt_q    <= '0;
            char_q   <= 7'h00;
            mstate_q <= 4'd0;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            cnt_q    <= cnt_d;
            char_q   <= char_d;
            mstate_q <= mstate_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
        end
    end

    assign sym_ready = (fsm_q == StIdle) && !done && !restart_eff;
    assign tx_char   = char_q;
    assign tx_strobe = (fsm_q == StStrobe);
    assign rx_reset  = (fsm_q == StRestart);
    assign err       = err_q;
    assign state     = mstate_q;

endmodule

// File: tb/tb_symbol_sequence_tx.sv
module tb_symbol_sequence_tx;

    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // DUT 0: default parameters
    logic       rst0, v0, rdy0, rs0, stb0, rxr0, err0, dn0;
    logic [2:0] id0;
    logic [6:0] ch0;
    logic [3:0] st0;

    symbol_sequence_tx u_dut0 (
        .clk(clk), .reset(rst0), .sym_valid(v0), .sym_id(id0), .sym_ready(rdy0),
        .restart(rs0), .tx_char(ch0), .tx_strobe(stb0), .rx_reset(rxr0),
        .err(err0), .state(st0), .done(dn0)
    );

    // DUT 1: STROBE_LEN=3, GAP_LEN=1
    logic       rst1, v1, rdy1, rs1, stb1, rxr1, err1, dn1;
    logic [2:0] id1;
    logic [6:0] ch1;
    logic [3:0] st1;

    symbol_sequence_tx #(.STROBE_LEN(3), .GAP_LEN(1)) u_dut1 (
        .clk(clk), .reset(rst1), .sym_valid(v1), .sym_id(id1), .sym_ready(rdy1),
        .restart(rs1), .tx_char(ch1), .tx_strobe(stb1), .rx_reset(rxr1),
        .err(err1), .state(st1), .done(dn1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [6:0] ch;
        logic [3:0] st;
    } exp_t;

    exp_t sb[$];

    // Scoreboard consumer: every rising strobe on DUT 0 must match a pushed entry.
    logic stb0_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (stb0) check("strobe_len1", {31'd0, stb0_prev}, 32'd0);
        if (stb0 && !stb0_prev) begin
            check("sb_pending", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_char", {25'd0, ch0}, {25'd0, e.ch});
                check("sb_state", {28'd0, st0}, {28'd0, e.st});
                check("sb_no_err", {31'd0, err0}, 32'd0);
            end
        end
        stb0_prev = stb0;
    end

    // Called at a negedge; returns at the negedge where sym_ready is seen high.
    task automatic wait_ready0(output int waited);
        waited = 0;
        while (!rdy0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!rdy0) check("ready_timeout", {31'd0, rdy0}, 32'd1);
    endtask

    task automatic send0(input logic [2:0] id, input logic [6:0] ch, input logic [3:0] st,
                         input logic ok, output int waited);
        exp_t e;
        wait_ready0(waited);
        if (ok) begin
            e.ch = ch;
            e.st = st;
            sb.push_back(e);
        end
        v0  = 1'b1;
        id0 = id;
        @(negedge clk);
        v0 = 1'b0;
        if (!ok) begin
            check("illegal_err", {31'd0, err0}, 32'd1);
            check("illegal_no_strobe", {31'd0, stb0}, 32'd0);
            check("illegal_state", {28'd0, st0}, {28'd0, st});
            @(negedge clk);
            check("err_one_cycle", {31'd0, err0}, 32'd0);
        end
    endtask

    task automatic pulse_restart0();
        rs0 = 1'b1;
        @(negedge clk);
        rs0 = 1'b0;
        check("rst_rx_reset", {31'd0, rxr0}, 32'd1);
        check("rst_char", {25'd0, ch0}, 32'd0);
        check("rst_state", {28'd0, st0}, 32'd0);
        @(negedge clk);
        check("rst_rx_reset_fall", {31'd0, rxr0}, 32'd0);
        check("rst_gap_not_ready", {31'd0, rdy0}, 32'd0);
        @(negedge clk);
        check("rst_ready_back", {31'd0, rdy0}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int ids[5]  = '{1, 2, 3, 4, 7};
        int chs[5]  = '{'h6B, 'h4F, 'h28, 'h0C, 'h23};
        int sts[5]  = '{2, 3, 4, 5, 10};

        rst0 = 1'b1; v0 = 1'b0; id0 = '0; rs0 = 1'b0;
        rst1 = 1'b1; v1 = 1'b0; id1 = '0; rs1 = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_char", {25'd0, ch0}, 32'd0);
        check("reset_strobe", {31'd0, stb0}, 32'd0);
        check("reset_rx_reset", {31'd0, rxr0}, 32'd0);
        check("reset_err", {31'd0, err0}, 32'd0);
        check("reset_state", {28'd0, st0}, 32'd0);
        check("reset_ready", {31'd0, rdy0}, 32'd1);
        check("reset_done", {31'd0, dn0}, 32'd0);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // Legal path k O ( FF #, three-cycle accept spacing
        for (int i = 0; i < 5; i++) begin
            send0(ids[i][2:0], chs[i][6:0], sts[i][3:0], 1'b1, w);
            if (i > 0) check("accept_spacing", w + 1, 32'd3);
        end
        repeat (3) @(negedge clk);
        check("acc_b_state", {28'd0, st0}, 32'd10);
        check("acc_b_done", {31'd0, dn0}, 32'd1);
        check("acc_b_not_ready", {31'd0, rdy0}, 32'd0);

        // Restart from terminal state
        pulse_restart0();

        // Restart coinciding with a request drops the request
        rs0 = 1'b1; v0 = 1'b1; id0 = 3'd1;
        #1 check("restart_blocks_ready", {31'd0, rdy0}, 32'd0);
        @(negedge clk);
        rs0 = 1'b0; v0 = 1'b0;
        check("restart_wins_rx_reset", {31'd0, rxr0}, 32'd1);
        check("restart_wins_no_strobe", {31'd0, stb0}, 32'd0);
        check("restart_wins_no_err", {31'd0, err0}, 32'd0);
        check("restart_wins_state", {28'd0, st0}, 32'd0);
        repeat (2) @(negedge clk);

        // Illegal refusal
        send0(3'd5, 7'h00, 4'd0, 1'b0, w);
        send0(3'd0, 7'h58, 4'd1, 1'b1, w);
        send0(3'd0, 7'h00, 4'd1, 1'b0, w);

        // Abort to REJ, then requests while done
        pulse_restart0();
        send0(3'd0, 7'h58, 4'd1, 1'b1, w);
        send0(3'd6, 7'h16, 4'd9, 1'b1, w);
        repeat (3) @(negedge clk);
        check("rej_state", {28'd0, st0}, 32'd9);
        for (int i = 0; i < 3; i++) begin
            v0 = 1'b1; id0 = 3'(i);
            #1 check("done_not_ready", {31'd0, rdy0}, 32'd0);
            @(negedge clk);
            check("done_err", {31'd0, err0}, 32'd1);
            check("done_no_strobe", {31'd0, stb0}, 32'd0);
        end
        v0 = 1'b0;
        @(negedge clk);
        check("done_err_clear", {31'd0, err0}, 32'd0);

        // STROBE_LEN=3, GAP_LEN=1
        v1 = 1'b1; id1 = 3'd1;
        @(negedge clk);
        v1 = 1'b0;
        check("p_char", {25'd0, ch1}, 32'h6B);
        check("p_state", {28'd0, st1}, 32'd2);
        check("p_strobe1", {31'd0, stb1}, 32'd1);
        @(negedge clk);
        check("p_strobe2", {31'd0, stb1}, 32'd1);
        @(negedge clk);
        check("p_strobe3", {31'd0, stb1}, 32'd1);
        check("p_busy", {31'd0, rdy1}, 32'd0);
        @(negedge clk);
        check("p_strobe_fall", {31'd0, stb1}, 32'd0);
        check("p_ready_at_4", {31'd0, rdy1}, 32'd1);
        v1 = 1'b1; id1 = 3'd2;
        @(negedge clk);
        v1 = 1'b0;
        check("p_strobe_again", {31'd0, stb1}, 32'd1);
        check("p_state2", {28'd0, st1}, 32'd3);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        check("p_rst_strobe", {31'd0, stb1}, 32'd0);
        check("p_rst_char", {25'd0, ch1}, 32'd0);
        check("p_rst_state", {28'd0, st1}, 32'd0);
        check("p_rst_ready", {31'd0, rdy1}, 32'd1);
        check("p_rst_rx_reset", {31'd0, rxr1}, 32'd0);
        check("p_rst_err", {31'd0, err1}, 32'd0);

        check("sb_drain", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
